// File: rtl/layer_out_serializer_pkg.sv
// layer_out_serializer_pkg: shared serializer state encoding, index sizing helper
// and the per-layer geometry constants of the network.
`default_nettype none

package layer_out_serializer_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   localparam int LAYER_DATA_WIDTH       = 16;
   localparam int NUM_NEURON_LAYER1      = 30;
   localparam int NUM_NEURON_LAYER2      = 30;
   localparam int NUM_NEURON_LAYER3      = 10;
   localparam int NEXT_LAYER_INPUT_WIDTH = LAYER_DATA_WIDTH;

   // Word index width; a single-neuron layer still needs a 1-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/layer_ser_pending.sv
// layer_ser_pending: one-vector holding register with valid flag, used to absorb
// a capture that arrives while the previous vector is still being replayed.
`default_nettype none

module layer_ser_pending #(
   parameter int WIDTH = 480
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             take,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full
);

   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 1'b0;
         dout <= '0;
      end else if (load) begin
         full <= 1'b1;
         dout <= din;
      end else if (take) begin
         full <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/layer_out_serializer.sv
// layer_out_serializer: captures a full layer output vector and replays it one word
// per cycle, neuron 0 first. Define LAYER_SER_DOUBLE_BUF_EN for the pending buffer.
`default_nettype none

module layer_out_serializer
   import layer_out_serializer_pkg::*;
#(
   parameter int numNeuron = 30,
   parameter int dataWidth = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [numNeuron*dataWidth-1:0] in_data,
   input  logic [numNeuron-1:0]           in_valid,
   output logic [dataWidth-1:0]           out_data,
   output logic                           out_valid,
   output logic                           out_last,
   output logic                           busy,
   output logic                           overflow,
   output logic                           skew_err
);

   localparam int            IW   = idx_width(numNeuron);
   localparam int            VW   = numNeuron * dataWidth;
   localparam logic [IW-1:0] LAST = IW'(numNeuron - 1);

   ser_state_t    state;
   logic [IW-1:0] index;
   logic [VW-1:0] shift_buf;

   logic          capture;
   logic          partial;
   logic          in_shift;
   logic          at_last;
   logic          early;
   logic          reload;
   logic          drop;
   logic          pend_full;
   logic          pend_load;
   logic          pend_take;
   logic [VW-1:0] pend_data;
   logic [IW-1:0] next_idx;
   logic          next_valid;
   logic          next_pend_full;

   assign capture  = &in_valid;
   assign partial  = (|in_valid) & ~capture;
   assign in_shift = (state == SHIFT);
   assign at_last  = in_shift && (index == LAST);
   assign early    = in_shift && !at_last && capture;
   // A fresh capture always wins on the last word; pending waits another round.
   assign reload   = capture && (!in_shift || at_last);
   assign next_idx = (index == LAST) ? '0 : index + IW'(1);

`ifdef LAYER_SER_DOUBLE_BUF_EN
   assign pend_load = early && !pend_full;
   assign pend_take = at_last && !capture && pend_full;
   assign drop      = early && pend_full;

   layer_ser_pending #(
      .WIDTH(VW)
   ) u_pending (
      .clk  (clk),
      .rst  (rst),
      .load (pend_load),
      .take (pend_take),
      .din  (in_data),
      .dout (pend_data),
      .full (pend_full)
   );
`else
   assign pend_load = 1'b0;
   assign pend_take = 1'b0;
   assign pend_full = 1'b0;
   assign pend_data = '0;
   assign drop      = early;
`endif

   assign next_valid     = reload || pend_take || (in_shift && !at_last);
   assign next_pend_full = (pend_full | pend_load) & ~pend_take;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         index     <= '0;
         shift_buf <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         overflow  <= 1'b0;
         skew_err  <= 1'b0;
      end else begin
         if (partial) skew_err <= 1'b1;
         if (drop)    overflow <= 1'b1;
         busy <= next_valid | next_pend_full;

         if (reload) begin
            state     <= SHIFT;
            index     <= '0;
            shift_buf <= in_data;
            out_data  <= in_data[dataWidth-1:0];
            out_valid <= 1'b1;
            out_last  <= (numNeuron == 1);
         end else if (pend_take) begin
            state     <= SHIFT;
            index     <= '0;
            shift_buf <= pend_data;
            out_data  <= pend_data[dataWidth-1:0];
            out_valid <= 1'b1;
            out_last  <= (numNeuron == 1);
         end else if (at_last) begin
            state     <= IDLE;
            index     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end else if (in_shift) begin
            index     <= next_idx;
            out_data  <= shift_buf[int'(next_idx)*dataWidth +: dataWidth];
            out_last  <= (next_idx == LAST);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_layer_out_serializer.sv
// tb_layer_out_serializer: directed checks of a 4-neuron and a 1-neuron serializer.
`default_nettype none

module tb_layer_out_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] in_data = '0;
   logic [3:0]  in_valid = '0;
   logic [15:0] out_data;
   logic        out_valid, out_last, busy, overflow, skew_err;

   logic [15:0] in_data1 = '0;
   logic [0:0]  in_valid1 = '0;
   logic [15:0] out_data1;
   logic        out_valid1, out_last1, busy1, overflow1, skew_err1;

   int vectors = 0;
   int miscompares = 0;

   localparam logic [63:0] VEC_A = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
   localparam logic [63:0] VEC_B = {16'h0008, 16'h0007, 16'h0006, 16'h0005};

   layer_out_serializer #(.numNeuron(4), .dataWidth(16)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
      .busy(busy), .overflow(overflow), .skew_err(skew_err)
   );

   layer_out_serializer #(.numNeuron(1), .dataWidth(16)) dut1 (
      .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
      .out_data(out_data1), .out_valid(out_valid1), .out_last(out_last1),
      .busy(busy1), .overflow(overflow1), .skew_err(skew_err1)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      in_valid = '0;
      in_valid1 = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      vectors++; if (out_data !== 16'h0) begin miscompares++; $display("FAIL reset out_data got %h exp 0000", out_data); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
      vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset out_last got %b exp 0", out_last); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy got %b exp 0", busy); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset overflow got %b exp 0", overflow); end
      vectors++; if (skew_err !== 1'b0) begin miscompares++; $display("FAIL reset skew_err got %b exp 0", skew_err); end
   endtask

   task automatic test_single_vector();
      apply_reset();
      in_data = VEC_A; in_valid = 4'hF;
      tick();
      in_valid = 4'h0;
      for (int k = 0; k < 4; k++) begin
         vectors++; if (out_data !== 16'(k + 1)) begin miscompares++; $display("FAIL single data k=%0d got %h exp %h", k, out_data, 16'(k + 1)); end
         vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single valid k=%0d got %b exp 1", k, out_valid); end
         vectors++; if (out_last !== (k == 3)) begin miscompares++; $display("FAIL single last k=%0d got %b exp %b", k, out_last, (k == 3)); end
         vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single busy k=%0d got %b exp 1", k, busy); end
         tick();
      end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single tail valid got %b exp 0", out_valid); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single tail busy got %b exp 0", busy); end
      vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL single tail last got %b exp 0", out_last); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      in_data = VEC_A; in_valid = 4'hF;
      tick();
      in_valid = 4'h0;
      for (int k = 0; k < 8; k++) begin
         vectors++; if (out_data !== 16'(k + 1)) begin miscompares++; $display("FAIL seamless data k=%0d got %h exp %h", k, out_data, 16'(k + 1)); end
         vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL seamless valid k=%0d got %b exp 1", k, out_valid); end
         vectors++; if (out_last !== (k % 4 == 3)) begin miscompares++; $display("FAIL seamless last k=%0d got %b exp %b", k, out_last, (k % 4 == 3)); end
         vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL seamless overflow k=%0d got %b exp 0", k, overflow); end
         if (k == 3) begin in_data = VEC_B; in_valid = 4'hF; end
         tick();
         in_valid = 4'h0;
      end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL seamless tail valid got %b exp 0", out_valid); end
   endtask

   task automatic test_early_capture();
      apply_reset();
      in_data = VEC_A; in_valid = 4'hF;
      tick();
      in_valid = 4'h0;
      tick();
      in_data = VEC_B; in_valid = 4'hF;
      tick();
      in_valid = 4'h0;
      vectors++; if (out_data !== 16'h0003) begin miscompares++; $display("FAIL early word3 got %h exp 0003", out_data); end
`ifdef LAYER_SER_DOUBLE_BUF_EN
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL early overflow got %b exp 0", overflow); end
      tick();
      tick();
      for (int k = 0; k < 4; k++) begin
         vectors++; if (out_data !== 16'(k + 5)) begin miscompares++; $display("FAIL early pend data k=%0d got %h exp %h", k, out_data, 16'(k + 5)); end
         vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL early pend valid k=%0d got %b exp 1", k, out_valid); end
         vectors++; if (out_last !== (k == 3)) begin miscompares++; $display("FAIL early pend last k=%0d got %b exp %b", k, out_last, (k == 3)); end
         tick();
      end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL early pend overflow got %b exp 0", overflow); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL early pend tail busy got %b exp 0", busy); end
`else
      vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL early overflow got %b exp 1", overflow); end
      tick();
      vectors++; if (out_last !== 1'b1) begin miscompares++; $display("FAIL early last got %b exp 1", out_last); end
      tick();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL early drop valid got %b exp 0", out_valid); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL early drop busy got %b exp 0", busy); end
      vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL early sticky overflow got %b exp 1", overflow); end
`endif
   endtask

   task automatic test_skew();
      apply_reset();
      in_data = VEC_B; in_valid = 4'b0011;
      tick();
      in_valid = 4'h0;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL skew valid got %b exp 0", out_valid); end
      vectors++; if (skew_err !== 1'b1) begin miscompares++; $display("FAIL skew flag got %b exp 1", skew_err); end
      tick();
      vectors++; if (skew_err !== 1'b1) begin miscompares++; $display("FAIL skew sticky got %b exp 1", skew_err); end
      in_data = VEC_A; in_valid = 4'hF;
      tick();
      in_valid = 4'h0;
      for (int k = 0; k < 4; k++) begin
         vectors++; if (out_data !== 16'(k + 1) || out_valid !== 1'b1) begin miscompares++; $display("FAIL skew stream k=%0d got %h/%b exp %h/1", k, out_data, out_valid, 16'(k + 1)); end
         tick();
      end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL skew overflow got %b exp 0", overflow); end
   endtask

   task automatic test_reset_mid_shift();
      apply_reset();
      in_valid = 4'b0100;
      tick();
      in_data = VEC_A; in_valid = 4'hF;
      tick();
      in_valid = 4'h0;
      tick();
      vectors++; if (out_data !== 16'h0002) begin miscompares++; $display("FAIL rstmid pre data got %h exp 0002", out_data); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++; if (out_data !== 16'h0) begin miscompares++; $display("FAIL rstmid data got %h exp 0000", out_data); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid valid got %b exp 0", out_valid); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid busy got %b exp 0", busy); end
      vectors++; if (skew_err !== 1'b0) begin miscompares++; $display("FAIL rstmid skew_err got %b exp 0", skew_err); end
      for (int k = 0; k < 4; k++) begin
         vectors++; if (out_last !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid quiet k=%0d got last %b valid %b exp 0/0", k, out_last, out_valid); end
         tick();
      end
   endtask

   task automatic test_single_neuron();
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         in_data1 = 16'hA000 + 16'(i); in_valid1 = 1'b1;
         tick();
         vectors++; if (out_data1 !== 16'hA000 + 16'(i)) begin miscompares++; $display("FAIL n1 data i=%0d got %h exp %h", i, out_data1, 16'hA000 + 16'(i)); end
         vectors++; if (out_valid1 !== 1'b1 || out_last1 !== 1'b1) begin miscompares++; $display("FAIL n1 valid/last i=%0d got %b/%b exp 1/1", i, out_valid1, out_last1); end
      end
      in_valid1 = 1'b0;
      tick();
      vectors++; if (out_valid1 !== 1'b0) begin miscompares++; $display("FAIL n1 tail valid got %b exp 0", out_valid1); end
      vectors++; if (overflow1 !== 1'b0) begin miscompares++; $display("FAIL n1 overflow got %b exp 0", overflow1); end
   endtask

   initial begin
      test_reset();
      test_single_vector();
      test_back_to_back();
      test_early_capture();
      test_skew();
      test_reset_mid_shift();
      test_single_neuron();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
